// File: rtl/rl_force_pkg.sv
// Shared types and saturating arithmetic for the RL force accumulator.
package rl_force_pkg;

  localparam int FORCE_W = 32;

  localparam logic [FORCE_W-1:0] FORCE_MAX = {1'b0, {(FORCE_W-1){1'b1}}};
  localparam logic [FORCE_W-1:0] FORCE_MIN = {1'b1, {(FORCE_W-1){1'b0}}};

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_ACCUM,
    ST_DRAIN,
    ST_DUMP
  } state_t;

  typedef struct packed {
    logic               sat;
    logic [FORCE_W-1:0] sum;
  } sat_sum_t;

  // One guard bit is enough: overflow shows up as the two top bits disagreeing.
  function automatic sat_sum_t sat_add(input logic [FORCE_W-1:0] a,
                                       input logic [FORCE_W-1:0] b);
    logic [FORCE_W:0] wide;
    sat_sum_t         r;
    wide  = {a[FORCE_W-1], a} + {b[FORCE_W-1], b};
    r.sat = wide[FORCE_W] ^ wide[FORCE_W-1];
    if (r.sat) r.sum = wide[FORCE_W] ? FORCE_MIN : FORCE_MAX;
    else       r.sum = wide[FORCE_W-1:0];
    return r;
  endfunction

endpackage

// File: rtl/rl_force_accumulator_out_buf.sv
// Two-entry valid/ready FIFO for dump words; an empty buffer passes a pushed word straight to its output.
module rl_force_out_buf #(
  parameter int PID_WIDTH  = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push_valid,
  input  logic [PID_WIDTH-1:0]  push_pid,
  input  logic [DATA_WIDTH-1:0] push_force,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [PID_WIDTH-1:0]  out_pid,
  output logic [DATA_WIDTH-1:0] out_force,
  output logic [1:0]            occupancy
);

  typedef struct packed {
    logic [PID_WIDTH-1:0]  pid;
    logic [DATA_WIDTH-1:0] frc;
  } entry_t;

  entry_t     entry_q [2];
  entry_t     entry_d [2];
  logic       wr_ptr_q, wr_ptr_d;
  logic       rd_ptr_q, rd_ptr_d;
  logic [1:0] count_q, count_d;

  logic   empty, pop, bypass, store, deq;
  entry_t head;

  always_comb begin
    // NOTE: every signal written here gets a default first; a path that skips one would infer a latch.
    entry_d   = entry_q;
    empty     = (count_q == 2'd0);
    head      = empty ? entry_t'{pid: push_pid, frc: push_force} : entry_q[rd_ptr_q];
    out_valid = !empty || push_valid;
    pop       = out_valid && out_ready;
    bypass    = empty && push_valid && pop;
    store     = push_valid && !bypass;
    deq       = pop && !empty;
    if (store) entry_d[wr_ptr_q] = entry_t'{pid: push_pid, frc: push_force};
    wr_ptr_d  = wr_ptr_q ^ store;
    rd_ptr_d  = rd_ptr_q ^ deq;
    count_d   = count_q + {1'b0, store} - {1'b0, deq};
  end

  // Idle outputs read as zero so the bypassed RAM register never leaks through.
  assign out_pid   = out_valid ? head.pid : '0;
  assign out_force = out_valid ? head.frc : '0;
  assign occupancy = count_q;

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: flops use <= so each one samples pre-edge values regardless of statement order.
    if (rst) begin
      entry_q[0] <= '0;
      entry_q[1] <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
    end else begin
      entry_q    <= entry_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

endmodule

// File: rtl/rl_force_accumulator.sv
// Per-particle force accumulator: clear, 2-stage read-modify-write accumulate with forwarding, then dump.
module rl_force_accumulator
  import rl_force_pkg::*;
#(
  parameter int DATA_WIDTH   = FORCE_W,
  parameter int PARTICLE_NUM = 256,
  parameter int PID_WIDTH    = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [PID_WIDTH-1:0]  in_pid,
  input  logic [DATA_WIDTH-1:0] in_force,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [PID_WIDTH-1:0]  out_pid,
  output logic [DATA_WIDTH-1:0] out_force,
  output logic                  busy,
  output logic                  done,
  output logic                  sat_flag
);

  localparam int                   ADDR_W   = (PARTICLE_NUM > 1) ? $clog2(PARTICLE_NUM) : 1;
  localparam logic [PID_WIDTH-1:0] LAST_PID = PID_WIDTH'(PARTICLE_NUM - 1);

  state_t                state_q, state_d;
  logic [PID_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  rd_all_q, rd_all_d;
  logic                  rd_valid_q, rd_valid_d;
  logic [PID_WIDTH-1:0]  rd_pid_q, rd_pid_d;
  logic                  s2_valid_q, s2_valid_d;
  logic                  s2_inrange_q, s2_inrange_d;
  logic [PID_WIDTH-1:0]  s2_pid_q, s2_pid_d;
  logic [DATA_WIDTH-1:0] s2_force_q, s2_force_d;
  logic                  fwd_q, fwd_d;
  logic [DATA_WIDTH-1:0] fwd_data_q, fwd_data_d;
  logic                  sat_q, sat_d;
  logic                  done_q, done_d;

  logic [DATA_WIDTH-1:0] mem [PARTICLE_NUM];
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic                  mem_wr_en, mem_rd_en;
  logic [ADDR_W-1:0]     mem_wr_addr, mem_rd_addr;
  logic [DATA_WIDTH-1:0] mem_wr_data;

  logic                  accept, in_range;
  logic                  s2_write;
  logic [DATA_WIDTH-1:0] s2_base;
  sat_sum_t              s2_res;
  logic [1:0]            buf_occ;

  // NOTE: the force array has no reset; a reset would block RAM inference, and CLEAR initialises it.
  always_ff @(posedge clk) begin
    if (mem_wr_en) mem[mem_wr_addr] <= mem_wr_data;
    if (mem_rd_en) rd_data_q <= mem[mem_rd_addr];
  end

  assign in_ready = (state_q == ST_ACCUM);
  assign accept   = in_valid && in_ready;
  assign in_range = (in_pid <= LAST_PID);

  // The write issued last cycle is not yet visible in rd_data_q, so forward it.
  assign s2_base  = fwd_q ? fwd_data_q : rd_data_q;
  assign s2_res   = sat_add(s2_base, s2_force_q);
  assign s2_write = s2_valid_q && s2_inrange_q;

  always_comb begin
    s2_valid_d   = accept;
    s2_inrange_d = in_range;
    s2_pid_d     = in_pid;
    s2_force_d   = in_force;
    fwd_d        = accept && in_range && s2_write && (in_pid == s2_pid_q);
    fwd_data_d   = s2_res.sum;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rd_all_d    = rd_all_q;
    rd_valid_d  = 1'b0;
    rd_pid_d    = rd_pid_q;
    sat_d       = sat_q;
    done_d      = 1'b0;
    mem_wr_en   = 1'b0;
    mem_wr_addr = s2_pid_q[ADDR_W-1:0];
    mem_wr_data = s2_res.sum;
    mem_rd_en   = accept && in_range;
    mem_rd_addr = in_pid[ADDR_W-1:0];

    if (s2_write) begin
      mem_wr_en = 1'b1;
      if (s2_res.sat) sat_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
          sat_d   = 1'b0;
        end
      end
      ST_CLEAR: begin
        mem_wr_en   = 1'b1;
        mem_wr_addr = cnt_q[ADDR_W-1:0];
        mem_wr_data = '0;
        cnt_d       = cnt_q + 1'b1;
        if (cnt_q == LAST_PID) state_d = ST_ACCUM;
      end
      ST_ACCUM: begin
        if (flush) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        state_d  = ST_DUMP;
        cnt_d    = '0;
        rd_all_d = 1'b0;
      end
      ST_DUMP: begin
        // Issue only while the buffer can absorb every word already requested.
        if (!rd_all_q && ((buf_occ + {1'b0, rd_valid_q}) < 2'd2)) begin
          mem_rd_en   = 1'b1;
          mem_rd_addr = cnt_q[ADDR_W-1:0];
          rd_valid_d  = 1'b1;
          rd_pid_d    = cnt_q;
          cnt_d       = cnt_q + 1'b1;
          if (cnt_q == LAST_PID) rd_all_d = 1'b1;
        end
        if (out_valid && out_ready && (out_pid == LAST_PID)) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      rd_all_q     <= 1'b0;
      rd_valid_q   <= 1'b0;
      rd_pid_q     <= '0;
      s2_valid_q   <= 1'b0;
      s2_inrange_q <= 1'b0;
      s2_pid_q     <= '0;
      s2_force_q   <= '0;
      fwd_q        <= 1'b0;
      fwd_data_q   <= '0;
      sat_q        <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rd_all_q     <= rd_all_d;
      rd_valid_q   <= rd_valid_d;
      rd_pid_q     <= rd_pid_d;
      s2_valid_q   <= s2_valid_d;
      s2_inrange_q <= s2_inrange_d;
      s2_pid_q     <= s2_pid_d;
      s2_force_q   <= s2_force_d;
      fwd_q        <= fwd_d;
      fwd_data_q   <= fwd_data_d;
      sat_q        <= sat_d;
      done_q       <= done_d;
    end
  end

  rl_force_out_buf #(
    .PID_WIDTH  (PID_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_out_buf (
    .clk        (clk),
    .rst        (rst),
    .push_valid (rd_valid_q),
    .push_pid   (rd_pid_q),
    .push_force (rd_data_q),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_pid    (out_pid),
    .out_force  (out_force),
    .occupancy  (buf_occ)
  );

  assign busy     = (state_q != ST_IDLE);
  assign done     = done_q;
  assign sat_flag = sat_q;

endmodule

// File: doc/rl_force_accumulator.md
# rl_force_accumulator

Downstream consumer of the range-limited (RL) force pipelines. It accepts one (particle id, partial force) pair per cycle and accumulates the partial forces into a per-particle force memory using a 2-stage read-modify-write with forwarding. On flush it streams every accumulated total out under a valid/ready handshake. It sits between the RL pipeline array output and the motion-update stage.

## Interface
- DATA_WIDTH, 32, force word width; signed two's-complement fixed-point.
- PARTICLE_NUM, 256, number of force-memory entries.
- PID_WIDTH, 8, particle id width; must satisfy 2^PID_WIDTH >= PARTICLE_NUM.

Ports:
- clk  in  1  single clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  pulse; starts a clear-then-accumulate run.
- in_valid  in  1  partial force present.
- in_ready  out  1  accumulator accepts input.
- in_pid  in  PID_WIDTH  target particle.
- in_force  in  DATA_WIDTH  signed partial force.
- flush  in  1  pulse; ends accumulation and starts the dump.
- out_valid  out  1  dump word present.
- out_ready  in  1  downstream accepts the dump word.
- out_pid  out  PID_WIDTH  particle id of the dump word.
- out_force  out  DATA_WIDTH  accumulated force.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse after the last dump handshake.
- sat_flag  out  1  sticky; set when any accumulation saturated.

## Operation
- FSM states are IDLE, CLEAR, ACCUM, DRAIN, DUMP.
- IDLE:
  - start moves to CLEAR and clears sat_flag.
  - flush is ignored.
- CLEAR:
  - Writes zero to address 0..PARTICLE_NUM-1, one address per cycle.
  - Moves to ACCUM after writing address PARTICLE_NUM-1.
  - start and flush are ignored.
- ACCUM:
  - in_ready=1 and an input is accepted on in_valid&in_ready.
  - Stage 1, cycle T: synchronous read of mem[in_pid].
  - Stage 2, cycle T+1: sum = rd_data + in_force, computed at DATA_WIDTH+1 bits, then clamped to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1]. The sum is written back to mem[pid].
  - If a clamp occurs, sat_flag is set.
  - Forwarding: if the stage-1 pid equals the stage-2 pid, the stage-2 sum replaces rd_data. Only a 1-deep hazard exists, because the memory is write-before-next-cycle-read.
  - in_pid values >= PARTICLE_NUM are accepted and dropped (no write). They do not set sat_flag.
- flush in ACCUM moves to DRAIN. An input accepted in the same cycle as flush is still accumulated.
- DRAIN: one cycle with in_ready=0, so the final stage-2 write completes. Then moves to DUMP.
- DUMP:
  - Reads addresses 0..PARTICLE_NUM-1 in order into a 2-entry output buffer.
  - A read issues when buffer occupancy + reads in flight < 2, which allows full throughput.
  - out_* present the buffer head. The head pops on out_valid&out_ready.
  - After the handshake of address PARTICLE_NUM-1, done=1 for one cycle and the FSM goes to IDLE.
- rst at any time:
  - FSM goes to IDLE.
  - The pipeline and output buffer are emptied.
  - sat_flag is cleared.
  - Memory contents are undefined until the next CLEAR.

## Timing
- Reset values: in_ready=0, out_valid=0, out_pid=0, out_force=0, busy=0, done=0, sat_flag=0.
- start at cycle S:
  - CLEAR runs cycles S+1..S+PARTICLE_NUM.
  - in_ready=1 from S+PARTICLE_NUM+1.
- Accumulate latency: the write lands 2 cycles after acceptance. Back-to-back same-pid inputs are summed exactly.
- flush at cycle F: DRAIN at F+1, DUMP from F+2, first out_valid at F+3.
- With out_ready held high:
  - PARTICLE_NUM consecutive out_valid cycles.
  - done is asserted the cycle after the last handshake.
- out_pid and out_force are stable while out_valid=1 and out_ready=0.
- sat_flag is updated in the same cycle as the saturating write.

## Structure
- Package rl_force_pkg holds:
  - the state enum;
  - FORCE_MAX and FORCE_MIN derived from DATA_WIDTH;
  - a saturating-add function.
- The force memory is inferred in-module as simple dual-port RAM with synchronous read.
- Sub-module rl_force_out_buf: 2-entry valid/ready FIFO carrying the pid/force pair, with an occupancy output used for read issue.

## Test plan
- Clear: PARTICLE_NUM=8, start, then flush immediately after CLEAR -> 8 outputs, pid 0..7, all force=0, then a done pulse.
- Hazard: inputs on consecutive cycles (3,+5), (3,+7), (3,-2), then flush -> pid 3 out_force=10 and all other pids 0.
- Saturation: (1, 0x7FFFFFF0) then (1, 0x00000100) -> pid 1 out_force=0x7FFFFFFF and sat_flag=1; a following start clears sat_flag.
- Backpressure: out_ready toggling 1,0,0,1 during DUMP -> no word lost or duplicated and outputs stable while stalled; exactly 8 handshakes.
- Flush together with input: in_valid=1 with (5,+4) in the same cycle as flush -> pid 5 out_force=4.
- Reset mid-DUMP after 3 handshakes -> all outputs return to reset values; a new start/flush produces a full 8-word zero dump.
